rr_arbiter_4: RTL and testbench

//  Four-channel round-robin arbiter. It is the select-generation stage that

---
 rtl/rr_arbiter_4.sv | 118 +++++++++++
 tb/tb_rr_arbiter_4.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-channel round-robin arbiter driving the select of a 4:1 data mux.
// One grant at a time, released by done, a dropped request or the MAX_HOLD limit.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam int HW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int LIMIT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last, last_nxt;
  logic [1:0]      sel_nxt;
  logic [3:0]      grant_nxt;
  logic            timeout_nxt;
  logic [HW-1:0]   hold_cnt, hold_cnt_nxt;

  logic            any_req;
  logic            at_limit;
  logic            release_now;
  logic            arbitrate;
  logic [1:0]      winner;

  // Search starts one past the last winner, so the previous owner comes last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int k = 1; k < 5; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign any_req  = |req;
  assign winner   = pick(req, last);
  assign at_limit = (MAX_HOLD != 0) && (hold_cnt == HW'(LIMIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    release_now = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        release_now = done || !req[sel] || at_limit;
        if (release_now && !any_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arbitrate = (state == IDLE) || release_now;

  // Output / datapath next values; all of them land in registers below.
  always_comb begin
    grant_nxt    = grant;
    sel_nxt      = sel;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    if (arbitrate) begin
      hold_cnt_nxt = '0;
      if (any_req) begin
        grant_nxt = 4'b0001 << winner;
        sel_nxt   = winner;
        last_nxt  = winner;
      end else begin
        grant_nxt = 4'b0000;
      end
    end else if (hold_cnt != {HW{1'b1}}) begin
      hold_cnt_nxt = hold_cnt + 1'b1;
    end
    // Pulse only when the hold limit alone forced the release.
    timeout_nxt = release_now && at_limit && !done && req[sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      busy     <= |grant_nxt;
      timeout  <= timeout_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: a vector table for arbitration order plus
// hand sequences for reset, hold-limit timeout and done/limit coincidence.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({name, ".grant"},   32'(grant),   32'(g));
    chk({name, ".sel"},     32'(sel),     32'(s));
    chk({name, ".busy"},    32'(busy),    32'(b));
    chk({name, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    // req, done -> grant, sel, busy, timeout   (starts from reset: ch0 highest)
    vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[2]  = '{4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[12] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[18] = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};

    // Reset asserted with all requests up, checked before any clock edge
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    #3;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Fresh reset between edges, then the vector table
    req = 4'b0000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].timeout);
    end

    // Hold-limit timeout with a single persistent requester
    req  = 4'b0000;
    done = 1'b0;
    rst  = 1'b1;
    #1;
    rst  = 1'b0;
    req  = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step();
    chk_all("timeout_pulse", 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("rehold%0d.timeout", i), 32'(timeout), 32'd0);
    end
    // done lands on the same cycle as the limit: release without a pulse
    done = 1'b1;
    step();
    chk_all("done_at_limit", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("after_coincide", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Reset mid-grant clears immediately; ch0 wins first afterwards
    req = 4'b1111;
    step();
    chk_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_all("post_rst_rotate", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
